// File: rtl/tpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tpu_ctrl_pkg
// Shared definitions for the systolic-array control blocks.
//   drain_state_t  : state encoding of the output-FIFO drain controller
//   count_width()  : width of the drain row counter for a given lane count
//   drain_length() : number of read cycles in one drain (flush or staggered)
// No ports; imported by fifo_drain_control and its sub-modules.
// -----------------------------------------------------------------------------
package tpu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } drain_state_t;

    // Wide enough to reach 2*fw-1, one past the last staggered read.
    function automatic int count_width(input int fw);
        return $clog2(2 * fw) + 1;
    endfunction

    // Flush drains every lane at once; staggered adds fw-1 cycles of skew.
    function automatic int drain_length(input int fw, input logic stagger);
        return stagger ? (2 * fw - 1) : fw;
    endfunction

endpackage

// File: rtl/drain_lane_mask.sv
// -----------------------------------------------------------------------------
// drain_lane_mask
// Combinational generator of the per-lane FIFO pop mask for a drain cycle.
// Usable for the load-side stagger as well, since the diagonal is identical.
// Ports:
//   count     [count_width] : current drain row counter
//   stagger   [1]           : 1 = diagonal de-skew, 0 = all lanes together
//   enable    [1]           : forces the mask to zero when low
//   lane_mask [fifo_width]  : one bit per lane, 1 = pop this cycle
// -----------------------------------------------------------------------------
module drain_lane_mask #(
    parameter int fifo_width  = 16,
    parameter int count_width = 6
) (
    input  logic [count_width-1:0] count,
    input  logic                   stagger,
    input  logic                   enable,
    output logic [fifo_width-1:0]  lane_mask
);

    // Staggered: lane i is live for fifo_width cycles starting at count=i.
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < fifo_width; i++) begin
            if (enable) begin
                if (stagger) begin
                    lane_mask[i] = (int'(count) >= i) && (int'(count) <= i + fifo_width - 1);
                end else begin
                    lane_mask[i] = (int'(count) < fifo_width);
                end
            end
        end
    end

endmodule

// File: rtl/fifo_drain_control.sv
// -----------------------------------------------------------------------------
// fifo_drain_control
// Drains one result tile from the per-column output FIFOs into the unified
// output buffer, either all lanes together (flush) or with diagonal de-skew.
// Optional feature macro: DRAIN_HALT_EN adds the 'halt' back-pressure input.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   active            : start request, sampled only while idle
//   stagger_drain     : drain mode, latched at start
//   base_addr         : first output buffer row, latched at start
//   halt              : (DRAIN_HALT_EN only) pauses reads while draining
//   fifo_rd_en        : per-lane FIFO pop
//   mem_wr_en         : output buffer write strobe (one cycle after the pop)
//   mem_wr_mask       : lanes valid in this write
//   mem_addr          : output buffer row address
//   busy              : high while draining or flushing
//   done              : high while idle
//   done_pulse        : one cycle on return to idle
// -----------------------------------------------------------------------------
module fifo_drain_control
    import tpu_ctrl_pkg::*;
#(
    parameter int fifo_width = 16,
    parameter int addr_width = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  active,
    input  logic                  stagger_drain,
    input  logic [addr_width-1:0] base_addr,
`ifdef DRAIN_HALT_EN
    input  logic                  halt,
`endif
    output logic [fifo_width-1:0] fifo_rd_en,
    output logic                  mem_wr_en,
    output logic [fifo_width-1:0] mem_wr_mask,
    output logic [addr_width-1:0] mem_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  done_pulse
);

    localparam int CW = count_width(fifo_width);

    drain_state_t          state;
    logic [CW-1:0]         count;
    logic [CW-1:0]         wr_idx;
    logic [CW-1:0]         last_count;
    logic                  stag_q;
    logic [addr_width-1:0] base_q;
    logic                  halt_now;
    logic                  read_issue;

`ifdef DRAIN_HALT_EN
    assign halt_now = halt;
`else
    assign halt_now = 1'b0;
`endif

    assign last_count = CW'(drain_length(fifo_width, stag_q) - 1);

    // A read issues on every un-halted DRAIN cycle; the mask only depends on
    // registered state, so a start request never reaches the FIFOs directly.
    assign read_issue = (state == DRAIN) && !halt_now;

    drain_lane_mask #(
        .fifo_width  (fifo_width),
        .count_width (CW)
    ) u_lane_mask (
        .count     (count),
        .stagger   (stag_q),
        .enable    (read_issue),
        .lane_mask (fifo_rd_en)
    );

    // Control FSM plus the write path, which trails the reads by one cycle to
    // match the FIFO read latency. FLUSH exists only to let the last write out.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            wr_idx      <= '0;
            stag_q      <= 1'b0;
            base_q      <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_mask <= '0;
            mem_addr    <= '0;
            busy        <= 1'b0;
            done        <= 1'b1;
            done_pulse  <= 1'b0;
        end else begin
            mem_wr_mask <= fifo_rd_en;
            mem_wr_en   <= |fifo_rd_en;
            done_pulse  <= 1'b0;

            case (state)
                IDLE: begin
                    if (active) begin
                        state  <= DRAIN;
                        stag_q <= stagger_drain;
                        base_q <= base_addr;
                        count  <= '0;
                        wr_idx <= '0;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (read_issue) begin
                        count <= count + CW'(1);
                        if (count == last_count) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    done_pulse <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            endcase

            // fifo_rd_en is zero in IDLE, so this never collides with the
            // wr_idx clear on start.
            if (|fifo_rd_en) begin
                mem_addr <= base_q + addr_width'(wr_idx);
                wr_idx   <= wr_idx + CW'(1);
            end
        end
    end

endmodule
